id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 126 ++++++++++++
 tb/tb_id_ex_stage.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, operand forwarding
// from EX and MEM, flush handling and a saturating stall-cycle counter.

// Forwarding mux for one source operand. The priority is $0, then EX, then
// MEM, then the register file.
module id_ex_fwd (
    input  logic [4:0]  src,
    input  logic [31:0] rf_data,
    input  logic        ex_hit_en,
    input  logic [4:0]  ex_dest,
    input  logic [31:0] ex_result,
    input  logic        mem_hit_en,
    input  logic [4:0]  mem_dest,
    input  logic [31:0] mem_result,
    output logic [31:0] opnd
);
    // The first match wins; $0 always reads as zero, whatever is in flight.
    always_comb begin
        opnd = rf_data;
        if (src == 5'd0)
            opnd = 32'd0;
        else if (ex_hit_en && (ex_dest == src))
            opnd = ex_result;
        else if (mem_hit_en && (mem_dest == src))
            opnd = mem_result;
    end
endmodule

module id_ex_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic [31:0]      id_rd1,
    input  logic [31:0]      id_rd2,
    input  logic [31:0]      id_imm,
    input  logic [7:0]       id_ctrl,
    input  logic             flush,
    input  logic [31:0]      ex_alu_result,
    input  logic             mem_reg_write,
    input  logic [4:0]       mem_dest,
    input  logic [31:0]      mem_result,
    output logic             ex_valid,
    output logic [4:0]       ex_rs,
    output logic [4:0]       ex_rt,
    output logic [4:0]       ex_dest,
    output logic [31:0]      ex_opa,
    output logic [31:0]      ex_opb,
    output logic [31:0]      ex_imm,
    output logic [7:0]       ex_ctrl,
    output logic             stall,
    output logic [CNT_W-1:0] stall_count
);
    localparam int NUM_SRC = 2;

    logic                          ex_fwd_en;
    logic [NUM_SRC-1:0][4:0]       src;
    logic [NUM_SRC-1:0][31:0]      rf_data;
    logic [NUM_SRC-1:0][31:0]      opnd;

    // A load in EX can't forward its data yet, so only ALU writers forward.
    assign ex_fwd_en = ex_valid & ex_ctrl[0] & ~ex_ctrl[1];

    // A load in EX feeding the ID instruction needs a one-cycle bubble.
    // Loads to $0 never matter, and a flush kills the ID instruction anyway.
    assign stall = ex_valid & ex_ctrl[1] & (ex_dest != 5'd0) & id_valid &
                   ((ex_dest == id_rs) | (ex_dest == id_rt)) & ~flush;

    assign src     = {id_rt, id_rs};
    assign rf_data = {id_rd2, id_rd1};

    genvar g;
    generate
        for (g = 0; g < NUM_SRC; g++) begin : g_fwd
            id_ex_fwd u_fwd (
                .src        (src[g]),
                .rf_data    (rf_data[g]),
                .ex_hit_en  (ex_fwd_en),
                .ex_dest    (ex_dest),
                .ex_result  (ex_alu_result),
                .mem_hit_en (mem_reg_write),
                .mem_dest   (mem_dest),
                .mem_result (mem_result),
                .opnd       (opnd[g])
            );
        end
    endgenerate

    // EX register: reset clears it, flush/stall insert a bubble, else capture.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_valid <= 1'b0;
            ex_rs    <= '0;
            ex_rt    <= '0;
            ex_dest  <= '0;
            ex_opa   <= '0;
            ex_opb   <= '0;
            ex_imm   <= '0;
            ex_ctrl  <= '0;
        end else if (flush || stall) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
        end else begin
            ex_valid <= id_valid;
            ex_rs    <= id_rs;
            ex_rt    <= id_rt;
            ex_dest  <= id_ctrl[5] ? id_rd : id_rt;
            ex_opa   <= opnd[0];
            ex_opb   <= opnd[1];
            ex_imm   <= id_imm;
            ex_ctrl  <= id_valid ? id_ctrl : 8'd0;
        end
    end

    // Count stall cycles, holding at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!reset)
            stall_count <= '0;
        else if (stall && (stall_count != {CNT_W{1'b1}}))
            stall_count <= stall_count + 1'b1;
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage. A second, narrow-counter instance shares
// all inputs so that counter saturation is reached in a few dozen cycles.
module tb_id_ex_stage;
    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rd1, id_rd2, id_imm;
    logic [7:0]  id_ctrl;
    logic        flush;
    logic [31:0] ex_alu_result;
    logic        mem_reg_write;
    logic [4:0]  mem_dest;
    logic [31:0] mem_result;
    logic        ex_valid;
    logic [4:0]  ex_rs, ex_rt, ex_dest;
    logic [31:0] ex_opa, ex_opb, ex_imm;
    logic [7:0]  ex_ctrl;
    logic        stall;
    logic [15:0] stall_count;

    logic        s_valid;
    logic [4:0]  s_rs, s_rt, s_dest;
    logic [31:0] s_opa, s_opb, s_imm;
    logic [7:0]  s_ctrl;
    logic        s_stall;
    logic [3:0]  s_count;

    int checks = 0;
    int failures = 0;

    localparam logic [7:0] ALU_RD = 8'h21;  // reg_write + reg_dst
    localparam logic [7:0] LOAD   = 8'h1B;  // reg_write, mem_read, mem_to_reg, alu_src

    id_ex_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_ctrl(id_ctrl), .flush(flush), .ex_alu_result(ex_alu_result),
        .mem_reg_write(mem_reg_write), .mem_dest(mem_dest), .mem_result(mem_result),
        .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest),
        .ex_opa(ex_opa), .ex_opb(ex_opb), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
        .stall(stall), .stall_count(stall_count)
    );

    id_ex_stage #(.CNT_W(4)) u_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_ctrl(id_ctrl), .flush(flush), .ex_alu_result(ex_alu_result),
        .mem_reg_write(mem_reg_write), .mem_dest(mem_dest), .mem_result(mem_result),
        .ex_valid(s_valid), .ex_rs(s_rs), .ex_rt(s_rt), .ex_dest(s_dest),
        .ex_opa(s_opa), .ex_opb(s_opb), .ex_imm(s_imm), .ex_ctrl(s_ctrl),
        .stall(s_stall), .stall_count(s_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then let registered outputs settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic id_set(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [7:0] ctrl);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rd1 = d1; id_rd2 = d2; id_ctrl = ctrl;
    endtask

    task automatic mem_set(input logic we, input logic [4:0] d, input logic [31:0] r);
        mem_reg_write = we; mem_dest = d; mem_result = r;
    endtask

    initial begin
        reset = 1'b0; flush = 1'b1; id_imm = 32'h100; ex_alu_result = 32'h0;
        id_set(1'b1, 5'd3, 5'd4, 5'd5, 32'h11, 32'h22, ALU_RD);
        mem_set(1'b0, 5'd0, 32'h0);
        #2;

        // Reset wins over capture and flush.
        tick();
        chk("rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_ctrl", {24'd0, ex_ctrl}, 32'd0);
        chk("rst_opa", ex_opa, 32'd0);
        chk("rst_dest", {27'd0, ex_dest}, 32'd0);
        chk("rst_count", {16'd0, stall_count}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);

        // Plain capture, one cycle after release.
        reset = 1'b1; flush = 1'b0;
        #1;
        chk("cap_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("cap_valid", {31'd0, ex_valid}, 32'd1);
        chk("cap_opa", ex_opa, 32'h11);
        chk("cap_opb", ex_opb, 32'h22);
        chk("cap_dest", {27'd0, ex_dest}, 32'd5);
        chk("cap_ctrl", {24'd0, ex_ctrl}, 32'h21);
        chk("cap_rs_rt", {22'd0, ex_rs, ex_rt}, {22'd0, 5'd3, 5'd4});
        chk("cap_imm", ex_imm, 32'h100);

        // EX forwarding beats a simultaneous MEM match.
        id_set(1'b1, 5'd1, 5'd2, 5'd7, 32'h0, 32'h0, ALU_RD);
        tick();
        id_set(1'b1, 5'd7, 5'd9, 5'd10, 32'h55, 32'h66, ALU_RD);
        ex_alu_result = 32'hDEAD;
        mem_set(1'b1, 5'd7, 32'hBEEF);
        tick();
        chk("exfwd_opa", ex_opa, 32'hDEAD);
        chk("exfwd_opb_rf", ex_opb, 32'h66);

        // MEM forwarding on A while B takes EX (EX now writes r10).
        id_set(1'b1, 5'd7, 5'd10, 5'd11, 32'h55, 32'h66, ALU_RD);
        ex_alu_result = 32'hAAAA;
        tick();
        chk("memfwd_opa", ex_opa, 32'hBEEF);
        chk("exfwd_opb", ex_opb, 32'hAAAA);

        // Load-use: one stall, a bubble, then MEM forwarding.
        mem_set(1'b0, 5'd0, 32'h0);
        id_set(1'b1, 5'd1, 5'd8, 5'd0, 32'h0, 32'h0, LOAD);
        tick();
        chk("ld_dest", {27'd0, ex_dest}, 32'd8);
        id_set(1'b1, 5'd2, 5'd8, 5'd9, 32'h0, 32'h77, ALU_RD);
        #1;
        chk("lu_stall", {31'd0, stall}, 32'd1);
        tick();
        chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
        chk("lu_bubble_ctrl", {24'd0, ex_ctrl}, 32'd0);
        chk("lu_count", {16'd0, stall_count}, 32'd1);
        mem_set(1'b1, 5'd8, 32'h1234);
        #1;
        chk("lu_stall_drop", {31'd0, stall}, 32'd0);
        tick();
        chk("lu_opb", ex_opb, 32'h1234);
        chk("lu_valid", {31'd0, ex_valid}, 32'd1);
        chk("lu_dest", {27'd0, ex_dest}, 32'd9);

        // A load to $0 never stalls and $0 never forwards.
        mem_set(1'b0, 5'd0, 32'h0);
        id_set(1'b1, 5'd1, 5'd0, 5'd0, 32'h0, 32'h0, LOAD);
        tick();
        id_set(1'b1, 5'd0, 5'd0, 5'd3, 32'h99, 32'h98, ALU_RD);
        mem_set(1'b1, 5'd0, 32'hFFFF);
        #1;
        chk("r0_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("r0_opa", ex_opa, 32'd0);
        chk("r0_opb", ex_opb, 32'd0);
        chk("r0_count", {16'd0, stall_count}, 32'd1);

        // Flush together with a load-use hazard: flush wins, nothing counted.
        mem_set(1'b0, 5'd0, 32'h0);
        id_set(1'b1, 5'd1, 5'd8, 5'd0, 32'h0, 32'h0, LOAD);
        tick();
        id_set(1'b1, 5'd8, 5'd2, 5'd4, 32'h0, 32'h0, ALU_RD);
        flush = 1'b1;
        #1;
        chk("fl_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("fl_valid", {31'd0, ex_valid}, 32'd0);
        chk("fl_ctrl", {24'd0, ex_ctrl}, 32'd0);
        chk("fl_count", {16'd0, stall_count}, 32'd1);
        flush = 1'b0;

        // Reset in the middle of a stall clears EX, so the stall drops.
        id_set(1'b1, 5'd1, 5'd8, 5'd0, 32'h0, 32'h0, LOAD);
        tick();
        id_set(1'b1, 5'd8, 5'd2, 5'd4, 32'h0, 32'h0, ALU_RD);
        #1;
        chk("rs_stall_pre", {31'd0, stall}, 32'd1);
        reset = 1'b0;
        tick();
        chk("rs_valid", {31'd0, ex_valid}, 32'd0);
        chk("rs_stall_post", {31'd0, stall}, 32'd0);
        chk("rs_count", {16'd0, stall_count}, 32'd0);
        reset = 1'b1;
        id_set(1'b1, 5'd3, 5'd4, 5'd5, 32'h44, 32'h0, ALU_RD);
        tick();
        chk("rel_valid", {31'd0, ex_valid}, 32'd1);
        chk("rel_opa", ex_opa, 32'h44);

        // Holding a self-dependent load in ID alternates capture and stall:
        // 40 edges give 20 stalls, saturating the 4-bit counter at 15.
        id_set(1'b1, 5'd8, 5'd8, 5'd0, 32'h0, 32'h0, LOAD);
        for (int i = 0; i < 40; i++) tick();
        chk("sat_count16", {16'd0, stall_count}, 32'd20);
        chk("sat_count4", {28'd0, s_count}, 32'hF);

        // One reset edge clears everything again.
        reset = 1'b0;
        tick();
        chk("fin_count16", {16'd0, stall_count}, 32'd0);
        chk("fin_count4", {28'd0, s_count}, 32'd0);
        chk("fin_outs", {ex_opa | ex_opb | ex_imm}, 32'd0);
        chk("fin_fields", {8'd0, ex_valid, ex_rs, ex_rt, ex_dest, ex_ctrl}, 32'd0);
        chk("fin_stall", {31'd0, stall}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
